// File: rtl/simon_pkg.sv
// Shared Simon 32/64 definitions used by the key schedule and the round logic
// of simon_pipeline.
//   SIMON_N  : word width in bits
//   SIMON_M  : number of key words in the master key
//   SIMON_T  : maximum number of rounds (sizes the round index counter)
//   SIMON_Z0 : z0 constant sequence; see z0_bit() for the bit ordering
//   SIMON_C  : round constant 2^n - 4, which folds "~k ^ 3" into one XOR
//   ks_state_t : key schedule FSM states
package simon_pkg;

    localparam int SIMON_N = 16;
    localparam int SIMON_M = 4;
    localparam int SIMON_T = 32;

    // Written so the first character of the published sequence is the MSB.
    // Element j of the sequence therefore sits at bit 61-j.
    localparam logic [61:0] SIMON_Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;

    localparam logic [SIMON_N-1:0] SIMON_C = 16'hFFFC;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_t;

    // Rotate a word right by r positions (0 < r < SIMON_N).
    function automatic logic [SIMON_N-1:0] ror16(input logic [SIMON_N-1:0] x,
                                                 input int unsigned r);
        return (x >> r) | (x << (SIMON_N - r));
    endfunction

    // Element j of the z0 sequence, counting from the leftmost character.
    function automatic logic z0_bit(input logic [5:0] j);
        return SIMON_Z0[6'd61 - j];
    endfunction

endpackage

// File: rtl/simon_ks_step.sv
// One Simon 32/64 key expansion step, purely combinational.
// Ports:
//   k_im1  : k[i-1]
//   k_im3  : k[i-3]
//   k_im4  : k[i-4]
//   z_bit  : z0[i-4]
//   k_out  : k[i]
module simon_ks_step
    import simon_pkg::*;
(
    input  logic [15:0] k_im1,
    input  logic [15:0] k_im3,
    input  logic [15:0] k_im4,
    input  logic        z_bit,
    output logic [15:0] k_out
);

    logic [15:0] tmp_a;
    logic [15:0] tmp_b;

    always_comb begin
        tmp_a = ror16(k_im1, 3) ^ k_im3;
        tmp_b = tmp_a ^ ror16(tmp_a, 1);
        // SIMON_C ^ k equals ~k ^ 3, so the complement and the constant
        // collapse into a single XOR term.
        k_out = SIMON_C ^ k_im4 ^ tmp_b ^ {15'd0, z_bit};
    end

endmodule

// File: rtl/simon_key_schedule.sv
// Iterative Simon 32/64 key expansion engine. It accepts a 64-bit master key
// over a valid/ready handshake, then writes one new round key per clock. All
// round keys are presented on a flat bus that stays stable in DONE.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   key_in     : master key, key_in[16*j+15:16*j] = k[j], j = 0..3
//   key_valid  : master key offer
//   key_ready  : high in IDLE and DONE, low while expanding
//   round_keys : round_keys[16*i+15:16*i] = k[i]
//   keys_valid : high while all ROUNDS keys are complete and stable
module simon_key_schedule
    import simon_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          key_in,
    input  logic                 key_valid,
    output logic                 key_ready,
    output logic [16*ROUNDS-1:0] round_keys,
    output logic                 keys_valid
);

    localparam int IDX_W = $clog2(SIMON_T);

    ks_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      k_q [ROUNDS];
    logic [15:0]      k_d [ROUNDS];
    logic             keys_valid_q, keys_valid_d;
    logic             key_ready_q, key_ready_d;

    logic             accept;
    logic [15:0]      step_out;
    logic [IDX_W-1:0] idx_m1, idx_m3, idx_m4;

    // Tap indices for the step. They only matter in EXPAND, where idx >= 4,
    // so the wrap-around they show in other states is never used.
    assign idx_m1 = idx_q - IDX_W'(1);
    assign idx_m3 = idx_q - IDX_W'(3);
    assign idx_m4 = idx_q - IDX_W'(SIMON_M);

    simon_ks_step u_step (
        .k_im1 (k_q[idx_m1]),
        .k_im3 (k_q[idx_m3]),
        .k_im4 (k_q[idx_m4]),
        .z_bit (z0_bit(6'(idx_m4))),
        .k_out (step_out)
    );

    assign accept = key_valid && key_ready_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        k_d          = k_q;
        keys_valid_d = keys_valid_q;
        key_ready_d  = key_ready_q;

        case (state_q)
            KS_IDLE, KS_DONE: begin
                if (accept) begin
                    // Only the first SIMON_M words are loaded; the rest keep
                    // stale values until the expansion overwrites them.
                    for (int j = 0; j < SIMON_M; j++) begin
                        k_d[j] = key_in[16*j +: 16];
                    end
                    idx_d        = IDX_W'(SIMON_M);
                    state_d      = KS_EXPAND;
                    keys_valid_d = 1'b0;
                    key_ready_d  = 1'b0;
                end
            end
            KS_EXPAND: begin
                k_d[idx_q] = step_out;
                if (idx_q == IDX_W'(ROUNDS - 1)) begin
                    state_d      = KS_DONE;
                    keys_valid_d = 1'b1;
                    key_ready_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d      = KS_IDLE;
                idx_d        = '0;
                keys_valid_d = 1'b0;
                key_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= KS_IDLE;
            idx_q        <= '0;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            for (int i = 0; i < ROUNDS; i++) begin
                k_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            keys_valid_q <= keys_valid_d;
            key_ready_q  <= key_ready_d;
            for (int i = 0; i < ROUNDS; i++) begin
                k_q[i] <= k_d[i];
            end
        end
    end

    for (genvar g = 0; g < ROUNDS; g++) begin : g_flat
        assign round_keys[16*g +: 16] = k_q[g];
    end

    assign keys_valid = keys_valid_q;
    assign key_ready  = key_ready_q;

endmodule

// File: tb/tb_simon_key_schedule.sv
// Directed bench for simon_key_schedule (ROUNDS = 32).
module tb_simon_key_schedule;

    localparam int NR = 32;

    localparam logic [63:0] KEY1  = 64'h1918_1110_0908_0100;
    localparam logic [63:0] KEY2  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] NOISE = 64'hDEAD_BEEF_CAFE_F00D;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       key_in;
    logic              key_valid;
    logic              key_ready;
    logic [16*NR-1:0]  round_keys;
    logic              keys_valid;

    int vecs = 0;
    int miss = 0;

    logic [15:0] model_k [NR];

    typedef struct {
        string       name;
        int          edge_no;
        int          word;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [5];

    always #5 clk = ~clk;

    simon_key_schedule #(.ROUNDS(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .round_keys (round_keys),
        .keys_valid (keys_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] get_k(input int i);
        return round_keys[16*i +: 16];
    endfunction

    // Reference key expansion written straight from the recurrence.
    task automatic model_fill(input logic [63:0] key);
        string z;
        logic [15:0] t;
        z = "11111010001001010110000111001101111101000100101011000011100110";
        for (int j = 0; j < 4; j++) model_k[j] = key[16*j +: 16];
        for (int i = 4; i < NR; i++) begin
            t = {model_k[i-1][2:0], model_k[i-1][15:3]} ^ model_k[i-3];
            t = t ^ {t[0], t[15:1]};
            model_k[i] = ~model_k[i-4] ^ t ^ 16'h0003 ^
                         ((z[i-4] == "1") ? 16'h0001 : 16'h0000);
        end
    endtask

    // Simon 32/64 encryption using the keys currently on the DUT bus.
    function automatic logic [31:0] encrypt(input logic [31:0] pt);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < NR; r++) begin
            t = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ get_k(r);
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check_all(input string tag, input logic [63:0] key);
        model_fill(key);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_k%0d", tag, i), {16'h0, get_k(i)}, {16'h0, model_k[i]});
        end
    endtask

    // Counts edges after the accept edge until keys_valid rises. Optionally
    // offers a different key at cycles 5 and 20, which must be ignored.
    task automatic wait_done(input int start_c, input bit pulse, input string tag);
        int lat;
        logic rdy_at_done;
        logic [63:0] held;
        lat = -1;
        rdy_at_done = 1'b0;
        held = key_in;
        for (int c = start_c; c <= 100; c++) begin
            if (pulse && (c == 5 || c == 20)) begin
                check($sformatf("%s_busy_ready_c%0d", tag, c), {31'h0, key_ready}, 32'h0);
                key_in    = NOISE;
                key_valid = 1'b1;
            end else begin
                key_in    = held;
                key_valid = 1'b0;
            end
            tick();
            if (keys_valid === 1'b1) begin
                lat = c;
                rdy_at_done = key_ready;
                break;
            end
        end
        key_valid = 1'b0;
        key_in    = held;
        check({tag, "_latency"}, lat, 28);
        check({tag, "_ready_at_done"}, {31'h0, rdy_at_done}, 32'h1);
    endtask

    task automatic accept_key(input logic [63:0] key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{"k0_after_E0", 0, 0, 16'h0100};
        tbl[1] = '{"k1_after_E0", 0, 1, 16'h0908};
        tbl[2] = '{"k2_after_E0", 0, 2, 16'h1110};
        tbl[3] = '{"k3_after_E0", 0, 3, 16'h1918};
        tbl[4] = '{"k4_after_E1", 1, 4, 16'h71C3};

        rst       = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;

        // Reset held for three cycles.
        repeat (3) tick();
        check("rst_round_keys_zero", {31'h0, (round_keys == '0)}, 32'h1);
        check("rst_keys_valid", {31'h0, keys_valid}, 32'h0);
        check("rst_key_ready", {31'h0, key_ready}, 32'h1);
        rst = 1'b1;
        tick();

        // Reference vector: early words from the table, then the full run.
        accept_key(KEY1);
        check("e0_keys_valid", {31'h0, keys_valid}, 32'h0);
        check("e0_key_ready", {31'h0, key_ready}, 32'h0);
        for (int v = 0; v < 5; v++) begin
            if (v > 0 && tbl[v].edge_no != tbl[v-1].edge_no) tick();
            check(tbl[v].name, {16'h0, get_k(tbl[v].word)}, {16'h0, tbl[v].exp});
        end
        wait_done(2, 1'b0, "vec1");
        check_all("vec1", KEY1);
        check("vec1_ciphertext", encrypt(32'h6565_6877), 32'hC69B_E9BB);

        // DONE holds the bus steady.
        tick();
        tick();
        check("done_hold_k31", {16'h0, get_k(31)}, {16'h0, model_k[31]});
        check("done_keys_valid", {31'h0, keys_valid}, 32'h1);

        // Re-key with all zeros directly from DONE.
        accept_key(64'h0);
        check("rekey_keys_valid_drop", {31'h0, keys_valid}, 32'h0);
        check("rekey_key_ready_drop", {31'h0, key_ready}, 32'h0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("rekey_k%0d_zero", j), {16'h0, get_k(j)}, 32'h0);
        end
        wait_done(1, 1'b0, "rekey");
        check_all("rekey", 64'h0);

        // Offers during EXPAND are ignored.
        accept_key(KEY1);
        wait_done(1, 1'b1, "busy");
        check_all("busy", KEY1);
        check("busy_ciphertext", encrypt(32'h6565_6877), 32'hC69B_E9BB);

        // Reset asserted in the 10th cycle of an expansion.
        accept_key(KEY2);
        repeat (9) tick();
        check("mid_still_expanding", {31'h0, key_ready}, 32'h0);
        rst = 1'b0;
        tick();
        check("mid_rst_round_keys_zero", {31'h0, (round_keys == '0)}, 32'h1);
        check("mid_rst_keys_valid", {31'h0, keys_valid}, 32'h0);
        check("mid_rst_key_ready", {31'h0, key_ready}, 32'h1);
        rst = 1'b1;
        tick();
        check("idle_after_rst_keys_valid", {31'h0, keys_valid}, 32'h0);
        accept_key(KEY1);
        wait_done(1, 1'b0, "post_rst");
        check_all("post_rst", KEY1);
        check("post_rst_ciphertext", encrypt(32'h6565_6877), 32'hC69B_E9BB);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
